vga_scanout: RTL and testbench

- Display-side reader for the data memory's video read port (vaddr/vdata).
- Generates 640x480@60 VGA timing from the core clock using a pixel-tick divider.
- Fetches framebuffer words through vaddr and serialises them as a 64x64 monochrome image, scaled 4x into a centred 256x256 window.
- Sits at top level beside dmem; vdata is a combinational, word-aligned read of vaddr.

---
 rtl/vga_scanout.sv | 173 +++++++++++++++++
 tb/tb_vga_scanout.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA 640x480@60 timing plus a 64x64 monochrome framebuffer reader, shown 4x scaled in a window.
// Defining VGA_SCANOUT_BORDER_EN draws a green 1-pixel ring just outside the window.
module vga_scanout #(
  parameter int unsigned PIX_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned WIN_X    = 192,
  parameter int unsigned WIN_Y    = 112,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [8:0]  vaddr,
  input  logic [31:0] vdata,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          tick;
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic          h_wrap, v_wrap;

  assign tick   = (div_q == DW'(PIX_DIV - 1));
  assign h_wrap = (h_q == HW'(H_TOTAL - 1));
  assign v_wrap = (v_q == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (tick) begin
      h_q <= h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_q <= v_wrap ? '0 : v_q + 1'b1;
      end
    end
  end

  // Stage 0: 12-bit offsets so positions left of / above the window wrap far above 255.
  logic [11:0] wx, wy;
  logic [5:0]  col, row;
  logic        active, win, hs_raw, vs_raw;

  assign wx     = 12'(h_q) - 12'(WIN_X);
  assign wy     = 12'(v_q) - 12'(WIN_Y);
  assign win    = (wx < 12'd256) && (wy < 12'd256);
  assign col    = 6'(wx >> 2);
  assign row    = 6'(wy >> 2);
  assign active = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
  assign hs_raw = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));

  // Stage 1
  logic [8:0] vaddr_q;
  logic [4:0] bit_q;
  logic       act_q, win_q, hs_q, vs_q, first_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vaddr_q <= '0;
      bit_q   <= '0;
      act_q   <= 1'b0;
      win_q   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      first_q <= 1'b0;
    end else if (tick) begin
      if (win) begin
        vaddr_q <= {row, col[5], 2'b00};
      end
      bit_q   <= col[4:0];
      act_q   <= active;
      win_q   <= win;
      hs_q    <= hs_raw;
      vs_q    <= vs_raw;
      first_q <= (h_q == '0) && (v_q == '0);
    end
  end

`ifdef VGA_SCANOUT_BORDER_EN
  localparam logic [11:0] BORDER_COLOR = 12'h0F0;
  logic x_edge, y_edge, x_in, y_in, ring_q;

  assign x_edge = (wx == 12'hFFF) || (wx == 12'd256);
  assign y_edge = (wy == 12'hFFF) || (wy == 12'd256);
  assign x_in   = (wx == 12'hFFF) || (wx <= 12'd256);
  assign y_in   = (wy == 12'hFFF) || (wy <= 12'd256);

  always_ff @(posedge clk) begin
    if (reset) begin
      ring_q <= 1'b0;
    end else if (tick) begin
      ring_q <= (x_edge && y_in) || (y_edge && x_in);
    end
  end
`endif

  // Stage 2
  logic [11:0] rgb_d, rgb_q;
  logic        de_q, hsync_q, vsync_q, fs_q;

  always_comb begin
    rgb_d = '0;
    if (!act_q) begin
      rgb_d = '0;
`ifdef VGA_SCANOUT_BORDER_EN
    end else if (ring_q) begin
      rgb_d = BORDER_COLOR;
`endif
    end else if (!win_q) begin
      rgb_d = BG_COLOR;
    end else if (vdata[bit_q]) begin
      rgb_d = FG_COLOR;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      // Evaluated every clock so the pulse is one clk wide regardless of PIX_DIV.
      fs_q <= first_q && tick;
      if (tick) begin
        rgb_q   <= rgb_d;
        de_q    <= act_q;
        hsync_q <= hs_q;
        vsync_q <= vs_q;
      end
    end
  end

  assign vaddr       = vaddr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-timing instance checked pixel by pixel through a scoreboard,
// plus a default-timing instance used for sync period and frame_start latency checks.
module tb_vga_scanout;

  localparam int HA = 258, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
  localparam int VA = 258, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int WX = 1, WY = 1;
  localparam logic [15:0] IDLE = 16'h6000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] mem [0:127];

  logic [8:0]  vaddr, vaddr_d;
  logic [31:0] vdata, vdata_d;
  logic        hsync, vsync, de, frame_start;
  logic        hsync_d, vsync_d, de_d, frame_start_d;
  logic [11:0] rgb, rgb_d;

  assign vdata   = mem[vaddr[8:2]];
  assign vdata_d = mem[vaddr_d[8:2]];

  vga_scanout #(
    .PIX_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .WIN_X(WX), .WIN_Y(WY)
  ) dut (
    .clk(clk), .reset(reset), .vaddr(vaddr), .vdata(vdata), .hsync(hsync), .vsync(vsync),
    .de(de), .rgb(rgb), .frame_start(frame_start)
  );

  vga_scanout dut_d (
    .clk(clk), .reset(reset), .vaddr(vaddr_d), .vdata(vdata_d), .hsync(hsync_d),
    .vsync(vsync_d), .de(de_d), .rgb(rgb_d), .frame_start(frame_start_d)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] val;
    int          h;
    int          v;
  } exp_t;
  exp_t expq[$];

  // Expected {frame_start, hsync, vsync, de, rgb} for counter position (h, v).
  function automatic logic [15:0] ref_pix(int h, int v);
    int wx, wy, word, bitn;
    logic hs, vs, de_e, fs_e;
    logic [11:0] c;
    wx   = h - WX;
    wy   = v - WY;
    hs   = !(h >= HA + HF && h < HA + HF + HS);
    vs   = !(v >= VA + VF && v < VA + VF + VS);
    de_e = (h < HA) && (v < VA);
    fs_e = (h == 0) && (v == 0);
    c    = 12'h000;
    if (de_e) begin
      if (wx >= 0 && wx < 256 && wy >= 0 && wy < 256) begin
        word = (wy / 4) * 2 + (wx / 4) / 32;
        bitn = (wx / 4) % 32;
        if (mem[word][bitn]) c = 12'hFFF;
      end
`ifdef VGA_SCANOUT_BORDER_EN
      else if (((wx == -1 || wx == 256) && wy >= -1 && wy <= 256) ||
               ((wy == -1 || wy == 256) && wx >= -1 && wx <= 256)) begin
        c = 12'h0F0;
      end
`endif
    end
    return {fs_e, hs, vs, de_e, c};
  endfunction

  // Producer: one expectation per pixel tick; an extra idle entry covers the pipeline fill.
  initial begin
    int mh, mv;
    bit fill;
    mh = 0;
    mv = 0;
    fill = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        expq.delete();
        expq.push_back('{IDLE, -1, -1});
        fill = 1'b1;
        mh = 0;
        mv = 0;
      end else begin
        if (fill) begin
          expq.push_back('{IDLE, -1, -1});
          fill = 1'b0;
        end
        expq.push_back('{ref_pix(mh, mv), mh, mv});
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv++;
          if (mv == VT) mv = 0;
        end
      end
    end
  end

  int cyc, fs_cnt, fs_t1, fs_t2, de_cnt, fg_cnt, ring_cnt, nprint;
  logic [8:0] vmax;

  // Monitor: pops and compares on every output tick.
  initial begin
    exp_t e;
    logic [15:0] act;
    cyc = 0; fs_cnt = 0; fs_t1 = 0; fs_t2 = 0;
    de_cnt = 0; fg_cnt = 0; ring_cnt = 0; nprint = 0; vmax = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      act = {frame_start, hsync, vsync, de, rgb};
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty cyc=%0d got=%h", cyc, act);
      end else begin
        e = expq.pop_front();
        if (act !== e.val) begin
          bad++;
          if (nprint < 20) begin
            nprint++;
            $display("FAIL pixel h=%0d v=%0d got=%h want=%h", e.h, e.v, act, e.val);
          end
        end
      end
      if (reset) begin
        fs_cnt = 0; de_cnt = 0; fg_cnt = 0; ring_cnt = 0; vmax = '0;
      end else begin
        if (vaddr > vmax) vmax = vaddr;
        if (frame_start) begin
          fs_cnt++;
          if (fs_cnt == 1) fs_t1 = cyc;
          else if (fs_cnt == 2) fs_t2 = cyc;
        end
        if (fs_cnt == 1) begin
          if (de) de_cnt++;
          if (rgb == 12'hFFF) fg_cnt++;
          if (rgb == 12'h0F0) ring_cnt++;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  int idle_err, vs_err;

  // Counts clocks until hsync_d reaches lvl, also watching blanking and vsync on the way.
  task automatic wait_hs(input logic lvl, output int n);
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      if (!de_d && rgb_d !== 12'h000) idle_err++;
      if (vsync_d !== 1'b1) vs_err++;
      if (hsync_d === lvl) done = 1'b1;
    end
  endtask

  initial begin
    int n0, nlow, nhigh;
    logic want_fs;
    idle_err = 0;
    vs_err = 0;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[0]   = 32'h0000_0001;
    mem[5]   = 32'h0001_0000;
    mem[127] = 32'h8000_0000;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3 * HT + 100) @(negedge clk);

    // Mid-frame reset for one clock.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      want_fs = (k == 4);
      total++;
      if (frame_start_d !== want_fs) begin
        bad++;
        $display("FAIL fs_latency clk=%0d got=%b want=%b", k, frame_start_d, want_fs);
      end
    end

    wait_hs(1'b0, n0);
    wait_hs(1'b1, nlow);
    wait_hs(1'b0, nhigh);
    chk("hsync_low_clk", nlow, 192);
    chk("hsync_period_clk", nlow + nhigh, 1600);
    chk("blank_rgb_zero", idle_err, 0);
    chk("vsync_idle_high", vs_err, 0);

    for (int i = 0; i < 80000 && fs_cnt < 2; i++) @(posedge clk);
    #2;
    chk("frame_count", fs_cnt, 2);
    chk("frame_len_clk", fs_t2 - fs_t1, HT * VT);
    chk("de_pixels", de_cnt, HA * VA);
    chk("fg_pixels", fg_cnt, 48);
`ifdef VGA_SCANOUT_BORDER_EN
    chk("ring_pixels", ring_cnt, 4 * (256 + 2) - 4);
`else
    chk("ring_pixels", ring_cnt, 0);
`endif
    chk("vaddr_max", int'(vmax), 'h1FC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
